dff_wr_arbiter: RTL and testbench

- Round-robin write arbiter and controller for a shared W-bit enable-style D register (next-state/register split, hold value when not enabled).
- N requesters compete for write access. One owner at a time drives the register's enable and data.
- Sits between multiple producer blocks and a single shared state register. Exposes the register contents and the current grant.
- Bounded ownership: a hold timer forces handoff when other requesters are waiting.

---
 rtl/dff_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dff_wr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter in front of a shared W-bit enable-style register.
// N requesters compete for ownership. The owner's write strobe and data
// drive the register. A hold timer forces a handoff when others are waiting.
// Optional macro DFF_WR_ARBITER_WRCNT_EN adds a committed-write counter and
// a forced-release pulse output.
module dff_wr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDXW     = 2
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    we_i,
  input  logic [N*W-1:0]  wdata_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] owner_o,
  output logic            busy_o,
  output logic [W-1:0]    q_o
`ifdef DFF_WR_ARBITER_WRCNT_EN
  ,
  output logic [15:0]     wr_count_o,
  output logic            hold_timeout_o
`endif
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [W-1:0]      q_q, q_d;
  logic              wr_en;
  logic              forced;

  logic [N-1:0]      others;
  logic [IDXW-1:0]   nxt_ptr;
  logic [IDXW:0]     pick_idle, pick_hand;
  logic [W-1:0]      wsel;

  // First set bit of mask at or above start, wrapping; MSB flags a hit.
  function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] mask,
                                            input logic [IDXW-1:0] start);
    logic            found;
    logic [IDXW-1:0] sel;
    logic [N-1:0]    sh;
    int unsigned     idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(start) + k) % N;
      sh  = mask >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        sel   = IDXW'(idx);
      end
    end
    return {found, sel};
  endfunction

  // Arbitration candidates and owner's write data.
  always_comb begin
    others    = req_i & ~gnt_q;
    nxt_ptr   = IDXW'((32'(owner_q) + 32'd1) % N);
    pick_idle = rr_pick(req_i, ptr_q);
    pick_hand = rr_pick(others, nxt_ptr);
    wsel      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) wsel = wdata_i[i*W +: W];
    end
  end

  // Next-state: grant selection, hold timer, release and register enable.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    wr_en   = 1'b0;
    forced  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_idle[IDXW]) begin
          owner_d = pick_idle[IDXW-1:0];
          gnt_d   = N'(1) << pick_idle[IDXW-1:0];
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        wr_en  = |(gnt_q & we_i);
        forced = (cnt_q == MaxCnt) && (|others);
        if (!(|(req_i & gnt_q)) || forced) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (pick_hand[IDXW]) begin
            // Zero-gap handoff to the next waiting requester.
            owner_d = pick_hand[IDXW-1:0];
            gnt_d   = N'(1) << pick_hand[IDXW-1:0];
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end else if (cnt_q != MaxCnt) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    q_d = wr_en ? wsel : q_q;
  end

  // State, pointer, hold counter and shared register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      if (wr_en) q_q <= q_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = |gnt_q;
  assign q_o     = q_q;

`ifdef DFF_WR_ARBITER_WRCNT_EN
  logic [15:0] wr_count_q;
  logic        hold_timeout_q;

  // Committed-write counter and one-cycle forced-release pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_count_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      if (wr_en) wr_count_q <= wr_count_q + 16'd1;
      hold_timeout_q <= forced;
    end
  end

  assign wr_count_o     = wr_count_q;
  assign hold_timeout_o = hold_timeout_q;
`endif

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Randomized self-checking bench for dff_wr_arbiter against a behavioural
// ownership model, plus directed sequences with literal expectations.
module tb_dff_wr_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned MaxHold = 4;
  localparam int unsigned IdxW    = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, we;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    gnt;
  logic [IdxW-1:0] owner;
  logic            busy;
  logic [W-1:0]    q;
`ifdef DFF_WR_ARBITER_WRCNT_EN
  logic [15:0]     wr_count;
  logic            hold_timeout;
`endif

  dff_wr_arbiter #(.N(N), .W(W), .MAX_HOLD(MaxHold), .IDXW(IdxW)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .req_i          (req),
    .we_i           (we),
    .wdata_i        (wdata),
    .gnt_o          (gnt),
    .owner_o        (owner),
    .busy_o         (busy),
    .q_o            (q)
`ifdef DFF_WR_ARBITER_WRCNT_EN
    ,
    .wr_count_o     (wr_count),
    .hold_timeout_o (hold_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: who owns (-1 idle), how many cycles it has owned, rr pointer.
  int          m_owner, m_last, m_held, m_ptr;
  logic [W-1:0] m_q;
  logic [15:0]  m_wrcnt;
  logic         m_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] m, input int start);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (start + k) % int'(N);
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_held = 0; m_ptr = 0;
    m_q = '0; m_wrcnt = '0; m_to = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    logic [N-1:0] oth;
    int w;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = rr(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 0;
      end
    end else begin
      if (we[m_owner]) begin
        m_q = wdata[m_owner*W +: W];
        m_wrcnt++;
      end
      m_held++;
      oth = req & ~(N'(1) << m_owner);
      if (!req[m_owner] || (m_held >= int'(MaxHold) && oth != 0)) begin
        m_to  = req[m_owner] ? 1'b1 : (m_held >= int'(MaxHold) && oth != 0);
        m_ptr = (m_owner + 1) % int'(N);
        w = rr(oth, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // Single compare process: DUT outputs against the model, every cycle.
  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      logic [N-1:0] eg;
      eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("owner", 32'(owner), 32'(m_last));
      chk("busy", 32'(busy), 32'(eg != 0));
      chk("q", 32'(q), 32'(m_q));
`ifdef DFF_WR_ARBITER_WRCNT_EN
      chk("wr_count", 32'(wr_count), 32'(m_wrcnt));
      chk("hold_timeout", 32'(hold_timeout), 32'(m_to));
`endif
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*W-1:0] d);
    req = r; we = w; wdata = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset from mid-cycle; checks the grant drops with no edge.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_q", 32'(q), 32'h0);
    req = '0; we = '0;
    @(posedge clk);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    reset_n = 1'b0; req = '0; we = '0; wdata = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Single write and non-owner write.
    cyc(4'b0001, 4'b0001, 32'h0000_00A5);
    chk("wr_gnt_lat", 32'(gnt), 32'h1);
    chk("wr_idle_noq", 32'(q), 32'h0);
    cyc(4'b0001, 4'b0001, 32'h0000_00A5);
    chk("wr_q", 32'(q), 32'hA5);
    cyc(4'b0001, 4'b0000, 32'h0000_0011);
    chk("wr_hold", 32'(q), 32'hA5);
    cyc(4'b0001, 4'b0010, 32'h0000_3C00);
    chk("nonowner", 32'(q), 32'hA5);

    mid_reset();

    // Round robin with voluntary release, no idle gap.
    cyc(4'b1111, '0, '0);
    chk("rr_first", 32'(gnt), 32'h1);
    cyc(4'b1111, '0, '0);
    cyc(4'b1111, '0, '0);
    cyc(4'b1110, '0, '0);
    chk("rr_to1", 32'(gnt), 32'h2);
    cyc(4'b1101, '0, '0);
    chk("rr_to2", 32'(gnt), 32'h4);
    cyc(4'b1011, '0, '0);
    chk("rr_to3", 32'(gnt), 32'h8);
    cyc(4'b0111, '0, '0);
    chk("rr_to0", 32'(gnt), 32'h1);

    // Forced release alternates every MaxHold cycles.
    for (int k = 1; k <= 16; k++) begin
      cyc(4'b0011, '0, '0);
      chk("forced_alt", 32'(gnt), ((k / 4) % 2 != 0) ? 32'h2 : 32'h1);
    end
    // Sole requester keeps the grant.
    for (int k = 0; k < 22; k++) begin
      cyc(4'b0001, '0, '0);
      chk("sole_hold", 32'(gnt), 32'h1);
    end
    cyc(4'b0011, '0, '0);
    chk("sat_force", 32'(gnt), 32'h2);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0110, '0, '0);
      chk("own1", 32'(gnt), 32'h2);
    end
    // Write in the final owned cycle commits alongside the handoff.
    cyc(4'b0110, 4'b0010, 32'h0000_7700);
    chk("last_wr_q", 32'(q), 32'h77);
    chk("last_wr_gnt", 32'(gnt), 32'h4);
`ifdef DFF_WR_ARBITER_WRCNT_EN
    chk("last_wr_cnt", 32'(wr_count), 32'h1);
    chk("last_wr_to", 32'(hold_timeout), 32'h1);
`endif
    cyc(4'b0100, '0, '0);
`ifdef DFF_WR_ARBITER_WRCNT_EN
    chk("to_pulse_end", 32'(hold_timeout), 32'h0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ N'($urandom_range(0, (1 << N) - 1));
      cyc(r, N'($urandom_range(0, (1 << N) - 1)), $urandom);
      if ($urandom_range(0, 499) == 0) mid_reset();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
